// File: rtl/stack_ctrl_pkg.sv
// Shared defaults and command decode for the stack controller and its RAM.
package stack_ctrl_pkg;

  // Default geometry shared by ram_mem and stack_ctrl so the pair always agree.
  localparam int unsigned DefAddrWidth = 4;
  localparam int unsigned DefWidth     = 8;

  typedef enum logic [1:0] {
    CmdIdle    = 2'b00,
    CmdPop     = 2'b01,
    CmdPush    = 2'b10,
    CmdReplace = 2'b11
  } cmd_e;

  function automatic cmd_e cmd_decode(input logic push, input logic pop);
    return cmd_e'({push, pop});
  endfunction

endpackage

// File: rtl/ram_mem.sv
// Single-port RAM with registered, read-before-write output.
module ram_mem
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned WIDTH      = DefWidth
) (
  input  logic                  CLK,
  input  logic                  CE,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [WIDTH-1:0]      DATA_IN,
  output logic [WIDTH-1:0]      DATA_OUT
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] dout_q;

  // Old contents reach the output even when the same address is written.
  always_ff @(posedge CLK) begin
    dout_q <= mem_q[ADDR];
    if (CE) mem_q[ADDR] <= DATA_IN;
  end

  assign DATA_OUT = dout_q;

endmodule

// File: rtl/stack_top.sv
// Integration wrapper: stack_ctrl paired with its backing ram_mem.
module stack_top
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned WIDTH      = DefWidth
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                PUSH,
  input  logic                POP,
  input  logic                CLR,
  input  logic [WIDTH-1:0]    PUSH_DATA,
  output logic [WIDTH-1:0]    POP_DATA,
  output logic                POP_VALID,
  output logic [ADDR_WIDTH:0] COUNT,
  output logic                FULL,
  output logic                EMPTY,
  output logic                OVF,
  output logic                UNF
);

  logic                  mem_ce;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_din, mem_dout;

  stack_ctrl #(.ADDR_WIDTH(ADDR_WIDTH), .WIDTH(WIDTH)) u_ctrl (
    .CLK(CLK), .RST_N(RST_N), .PUSH(PUSH), .POP(POP), .CLR(CLR),
    .PUSH_DATA(PUSH_DATA), .POP_DATA(POP_DATA), .POP_VALID(POP_VALID),
    .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY), .OVF(OVF), .UNF(UNF),
    .MEM_CE(mem_ce), .MEM_ADDR(mem_addr), .MEM_DIN(mem_din), .MEM_DOUT(mem_dout)
  );

  ram_mem #(.ADDR_WIDTH(ADDR_WIDTH), .WIDTH(WIDTH)) u_ram (
    .CLK(CLK), .CE(mem_ce), .ADDR(mem_addr), .DATA_IN(mem_din), .DATA_OUT(mem_dout)
  );

endmodule

// File: rtl/stack_ctrl.sv
// LIFO controller driving ram_mem; pops return two cycles later on POP_DATA/POP_VALID.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned WIDTH      = DefWidth
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  PUSH,
  input  logic                  POP,
  input  logic                  CLR,
  input  logic [WIDTH-1:0]      PUSH_DATA,
  output logic [WIDTH-1:0]      POP_DATA,
  output logic                  POP_VALID,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  OVF,
  output logic                  UNF,
  output logic                  MEM_CE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [WIDTH-1:0]      MEM_DIN,
  input  logic [WIDTH-1:0]      MEM_DOUT
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  pend_q, pend_d;
  logic                  pop_valid_q, pop_valid_d;
  logic [WIDTH-1:0]      pop_data_q, pop_data_d;
  logic [ADDR_WIDTH-1:0] sp, sp_m1;
  cmd_e                  cmd;

  assign FULL  = (count_q == DepthCnt);
  assign EMPTY = (count_q == '0);
  // When full the low bits wrap to 0, so SP-1 still lands on DEPTH-1.
  assign sp    = count_q[ADDR_WIDTH-1:0];
  assign sp_m1 = sp - ADDR_WIDTH'(1);
  assign cmd   = cmd_decode(PUSH, POP);

  // Command decode: pointer, sticky flags, read-pending and RAM strobes.
  always_comb begin
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    pend_d   = 1'b0;
    MEM_CE   = 1'b0;
    MEM_ADDR = sp;
    if (CLR) begin
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      unique case (cmd)
        CmdIdle: ;
        CmdPush: begin
          if (FULL) begin
            ovf_d = 1'b1;
          end else begin
            MEM_CE  = 1'b1;
            count_d = count_q + (ADDR_WIDTH + 1)'(1);
          end
        end
        CmdPop: begin
          if (EMPTY) begin
            unf_d = 1'b1;
          end else begin
            MEM_ADDR = sp_m1;
            count_d  = count_q - (ADDR_WIDTH + 1)'(1);
            pend_d   = 1'b1;
          end
        end
        CmdReplace: begin
          MEM_CE = 1'b1;
          if (EMPTY) begin
            // Nothing to pop: degrade to a plain push at address 0.
            count_d = (ADDR_WIDTH + 1)'(1);
            unf_d   = 1'b1;
          end else begin
            // Read-before-write hands back the old top while the new word replaces it.
            MEM_ADDR = sp_m1;
            pend_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pop result capture; a CLR in the capture cycle drops the in-flight word.
  always_comb begin
    pop_valid_d = pend_q & ~CLR;
    pop_data_d  = pop_valid_d ? MEM_DOUT : pop_data_q;
  end

  // State registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      pend_q      <= 1'b0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      pend_q      <= pend_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
    end
  end

  assign COUNT     = count_q;
  assign OVF       = ovf_q;
  assign UNF       = unf_q;
  assign POP_VALID = pop_valid_q;
  assign POP_DATA  = pop_data_q;
  assign MEM_DIN   = PUSH_DATA;

endmodule

// File: tb/tb_stack_ctrl.sv
// Randomized bench for stack_ctrl + ram_mem against a queue-based LIFO model.
module tb_stack_ctrl;

  localparam int unsigned AW    = 2;
  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 2 ** AW;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          PUSH = 1'b0, POP = 1'b0, CLR = 1'b0;
  logic [W-1:0]  PUSH_DATA = '0;
  logic [W-1:0]  POP_DATA;
  logic          POP_VALID;
  logic [AW:0]   COUNT;
  logic          FULL, EMPTY, OVF, UNF;
  logic          MEM_CE;
  logic [AW-1:0] MEM_ADDR;
  logic [W-1:0]  MEM_DIN, MEM_DOUT;

  stack_ctrl #(.ADDR_WIDTH(AW), .WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .PUSH(PUSH), .POP(POP), .CLR(CLR),
    .PUSH_DATA(PUSH_DATA), .POP_DATA(POP_DATA), .POP_VALID(POP_VALID),
    .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY), .OVF(OVF), .UNF(UNF),
    .MEM_CE(MEM_CE), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT)
  );

  ram_mem #(.ADDR_WIDTH(AW), .WIDTH(W)) u_ram (
    .CLK(CLK), .CE(MEM_CE), .ADDR(MEM_ADDR), .DATA_IN(MEM_DIN), .DATA_OUT(MEM_DOUT)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: stack contents plus the two-stage pop return path.
  logic [W-1:0] stk[$];
  logic         m_ovf = 1'b0, m_unf = 1'b0;
  logic         p1_v = 1'b0, vis_v = 1'b0;
  logic [W-1:0] p1_d = '0, vis_d = '0;
  logic [W-1:0] got[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    m_ovf = 1'b0; m_unf = 1'b0;
    p1_v  = 1'b0; vis_v = 1'b0; vis_d = '0;
  endtask

  // One clock cycle: drive, check against the model, advance the model at the edge.
  task automatic step(input logic push, input logic pop, input logic clr, input logic [W-1:0] d);
    int unsigned  size;
    logic         exp_ce, addr_chk, new_v;
    logic [AW-1:0] exp_addr;
    logic [W-1:0] new_d;
    @(negedge CLK);
    PUSH = push; POP = pop; CLR = clr; PUSH_DATA = d;
    #1;
    size = stk.size();
    check_eq("count", 32'(COUNT), size);
    check_eq("full", 32'(FULL), 32'(size == DEPTH));
    check_eq("empty", 32'(EMPTY), 32'(size == 0));
    check_eq("ovf", 32'(OVF), 32'(m_ovf));
    check_eq("unf", 32'(UNF), 32'(m_unf));
    check_eq("pop_valid", 32'(POP_VALID), 32'(vis_v));
    check_eq("pop_data", 32'(POP_DATA), 32'(vis_d));
    if (POP_VALID) got.push_back(POP_DATA);
    exp_ce = 1'b0; addr_chk = 1'b1; new_v = 1'b0; new_d = '0;
    exp_addr = AW'(size % DEPTH);
    if (clr) begin
      addr_chk = 1'b0;
      stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (push && pop) begin
      exp_ce = 1'b1;
      if (size == 0) begin
        stk.push_back(d); m_unf = 1'b1; exp_addr = '0;
      end else begin
        new_v = 1'b1; new_d = stk[size-1]; stk[size-1] = d;
        exp_addr = AW'((size - 1) % DEPTH);
      end
    end else if (push) begin
      if (size == DEPTH) begin
        m_ovf = 1'b1; addr_chk = 1'b0;
      end else begin
        exp_ce = 1'b1; stk.push_back(d);
      end
    end else if (pop) begin
      if (size == 0) begin
        m_unf = 1'b1; addr_chk = 1'b0;
      end else begin
        new_v = 1'b1; new_d = stk.pop_back();
        exp_addr = AW'((size - 1) % DEPTH);
      end
    end
    check_eq("mem_ce", 32'(MEM_CE), 32'(exp_ce));
    check_eq("mem_din", 32'(MEM_DIN), 32'(d));
    if (addr_chk) check_eq("mem_addr", 32'(MEM_ADDR), 32'(exp_addr));
    @(posedge CLK);
    vis_v = clr ? 1'b0 : p1_v;
    if (vis_v) vis_d = p1_d;
    p1_v = new_v; p1_d = new_d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic async_reset();
    @(negedge CLK);
    PUSH = 1'b0; POP = 1'b0; CLR = 1'b0;
    RST_N = 1'b0;
    #2;
    model_reset();
    RST_N = 1'b1;
  endtask

  initial begin
    logic [W-1:0] want[4];
    model_reset();
    #12 RST_N = 1'b1;
    idle(3);
    check_eq("rst_count_const", 32'(COUNT), 0);
    check_eq("rst_empty_const", 32'(EMPTY), 1);

    // Fill, overflow, then drain back-to-back.
    step(1, 0, 0, 8'h11); step(1, 0, 0, 8'h22); step(1, 0, 0, 8'h33); step(1, 0, 0, 8'h44);
    step(1, 0, 0, 8'h55);
    idle(1);
    check_eq("full_count_const", 32'(COUNT), 4);
    check_eq("full_ovf_const", 32'({FULL, OVF}), 32'b11);
    got.delete();
    for (int i = 0; i < 4; i++) step(0, 1, 0, '0);
    idle(3);
    want = '{8'h44, 8'h33, 8'h22, 8'h11};
    check_eq("drain_len", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) check_eq("drain_data", 32'(got[i]), 32'(want[i]));

    // Underflow, then replace-on-empty behaves as a push.
    got.delete();
    step(0, 1, 0, '0);
    step(1, 1, 0, 8'h7A);
    idle(3);
    check_eq("unf_const", 32'({UNF, COUNT}), 32'({1'b1, 3'd1}));
    check_eq("empty_replace_no_valid", got.size(), 0);

    // Replace-top returns the old top; next pop returns the new word.
    step(0, 0, 1, '0);
    step(1, 0, 0, 8'h11); step(1, 0, 0, 8'h22);
    got.delete();
    step(1, 1, 0, 8'h99);
    step(0, 1, 0, '0);
    idle(3);
    check_eq("replace_len", got.size(), 2);
    if (got.size() == 2) begin
      check_eq("replace_old", 32'(got[0]), 32'h22);
      check_eq("replace_new", 32'(got[1]), 32'h99);
    end

    // Pop in flight killed by reset, then by CLR.
    step(1, 0, 0, 8'hA5);
    got.delete();
    step(0, 1, 0, '0);
    async_reset();
    idle(3);
    step(1, 0, 0, 8'h5A);
    step(0, 1, 0, '0);
    step(0, 0, 1, '0);
    idle(3);
    check_eq("flush_no_valid", got.size(), 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      r = $urandom_range(99);
      if (r < 1) async_reset();
      else step(logic'($urandom_range(1)), logic'($urandom_range(1)), logic'(r < 5),
                W'($urandom));
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
